// File: rtl/csr_irq_ctrl.sv
// -----------------------------------------------------------------------------
// csr_irq_ctrl
//   Machine-mode interrupt/trap sequencer placed in front of the CSR register
//   file. It synchronises the asynchronous timer/external interrupt lines and
//   builds mip from them. It decides whether to take an interrupt at a retiring
//   instruction boundary. It then sequences the CSR writes (mepc, mcause,
//   mstatus) and the PC redirect/flush for trap entry and for mret.
//
// Ports
//   clk            core clock
//   rst            asynchronous active-low reset
//   irq_timer      machine timer interrupt (level, async)
//   irq_ext        machine external interrupt (level, async)
//   mstatus_in     current mstatus (bit3 MIE, bit7 MPIE, [12:11] MPP)
//   mie_in         current mie (bit7 MTIE, bit11 MEIE)
//   mtvec_in       trap vector, [31:2] base, [1:0] mode
//   epc_in         current mepc (mret target)
//   inst_valid     write-back instruction retires this cycle
//   inst_pc        PC of the retiring instruction
//   is_mret        retiring instruction is mret
//   stall          pipeline stalled, no boundary this cycle
//   mip_out        {20'b0, MEIP@11, 3'b0, MTIP@7, 7'b0}
//   trap           one-cycle pulse on interrupt entry
//   epc_wr/epc_wdata, cause_wr/cause_wdata, mstatus_wr/mstatus_wdata
//                  CSR write strobes and data (data is 0 when strobe is 0)
//   flush          kill younger instructions
//   redirect       load PC from redirect_pc
//   redirect_pc    new PC
// -----------------------------------------------------------------------------
module csr_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_timer,
  input  logic        irq_ext,
  input  logic [31:0] mstatus_in,
  input  logic [31:0] mie_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] epc_in,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        is_mret,
  input  logic        stall,
  output logic [31:0] mip_out,
  output logic        trap,
  output logic        epc_wr,
  output logic [31:0] epc_wdata,
  output logic        cause_wr,
  output logic [31:0] cause_wdata,
  output logic        mstatus_wr,
  output logic [31:0] mstatus_wdata,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_STAT = 2'd2,
    ST_RET  = 2'd3
  } state_t;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  // Synchroniser chains and registered mip bits
  logic [SYNC_STAGES-1:0] sync_t_q;
  logic [SYNC_STAGES-1:0] sync_e_q;
  logic                   mtip_q;
  logic                   meip_q;

  // FSM state and captured cause
  state_t      state_q, state_d;
  logic [31:0] cause_q, cause_d;

  // Registered outputs and their next values
  logic        trap_q, trap_d;
  logic        epc_wr_q, epc_wr_d;
  logic [31:0] epc_wdata_q, epc_wdata_d;
  logic        cause_wr_q, cause_wr_d;
  logic [31:0] cause_wdata_q, cause_wdata_d;
  logic        mstatus_wr_q, mstatus_wr_d;
  logic [31:0] mstatus_wdata_q, mstatus_wdata_d;
  logic        flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // Decision terms
  logic        pend_e_s;
  logic        pend_t_s;
  logic        take_s;
  logic        bnd_s;
  logic [31:0] vec_base_s;
  logic [31:0] vec_target_s;
  logic [31:0] entry_status_s;
  logic [31:0] ret_status_s;
  logic        unused_s;

  assign pend_e_s = meip_q & mie_in[11];
  assign pend_t_s = mtip_q & mie_in[7];
  assign take_s   = mstatus_in[3] & (pend_e_s | pend_t_s);
  assign bnd_s    = inst_valid & ~stall;

  // Vector target uses the cause captured at entry, not the live pending lines,
  // so an irq that drops between SAVE and STAT cannot change the target.
  assign vec_base_s = {mtvec_in[31:2], 2'b00};
  assign vec_target_s = (VECTORED_EN && (mtvec_in[1:0] == 2'b01))
                      ? vec_base_s + {25'd0, cause_q[4:0], 2'b00}
                      : vec_base_s;

  // Entry: MPIE <= MIE, MIE <= 0, MPP <= M. Return: MIE <= MPIE, MPIE <= 1.
  always_comb begin
    entry_status_s        = mstatus_in;
    entry_status_s[7]     = mstatus_in[3];
    entry_status_s[3]     = 1'b0;
    entry_status_s[12:11] = 2'b11;
    ret_status_s          = mstatus_in;
    ret_status_s[3]       = mstatus_in[7];
    ret_status_s[7]       = 1'b1;
  end

  assign unused_s = ^{mie_in[31:12], mie_in[10:8], mie_in[6:0],
                      epc_in[1:0], cause_q[31:5]};

  // Next-state and next-output decode; outputs are registered from the next state
  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    trap_d          = 1'b0;
    epc_wr_d        = 1'b0;
    epc_wdata_d     = 32'd0;
    cause_wr_d      = 1'b0;
    cause_wdata_d   = 32'd0;
    mstatus_wr_d    = 1'b0;
    mstatus_wdata_d = 32'd0;
    flush_d         = 1'b0;
    redirect_d      = 1'b0;
    redirect_pc_d   = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (bnd_s && take_s) begin
          // Interrupt wins over a colliding mret; the mret PC becomes mepc.
          state_d       = ST_SAVE;
          cause_d       = pend_e_s ? CAUSE_EXT : CAUSE_TIMER;
          trap_d        = 1'b1;
          epc_wr_d      = 1'b1;
          epc_wdata_d   = inst_pc;
          cause_wr_d    = 1'b1;
          cause_wdata_d = pend_e_s ? CAUSE_EXT : CAUSE_TIMER;
          flush_d       = 1'b1;
        end else if (bnd_s && is_mret) begin
          state_d         = ST_RET;
          mstatus_wr_d    = 1'b1;
          mstatus_wdata_d = ret_status_s;
          flush_d         = 1'b1;
          redirect_d      = 1'b1;
          redirect_pc_d   = {epc_in[31:2], 2'b00};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE: begin
        state_d         = ST_STAT;
        mstatus_wr_d    = 1'b1;
        mstatus_wdata_d = entry_status_s;
        flush_d         = 1'b1;
        redirect_d      = 1'b1;
        redirect_pc_d   = vec_target_s;
      end
      ST_STAT: begin
        state_d = ST_IDLE;
      end
      ST_RET: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Synchronisers, mip, FSM state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_t_q        <= '0;
      sync_e_q        <= '0;
      mtip_q          <= 1'b0;
      meip_q          <= 1'b0;
      state_q         <= ST_IDLE;
      cause_q         <= 32'd0;
      trap_q          <= 1'b0;
      epc_wr_q        <= 1'b0;
      epc_wdata_q     <= 32'd0;
      cause_wr_q      <= 1'b0;
      cause_wdata_q   <= 32'd0;
      mstatus_wr_q    <= 1'b0;
      mstatus_wdata_q <= 32'd0;
      flush_q         <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_pc_q   <= 32'd0;
    end else begin
      sync_t_q        <= {sync_t_q[SYNC_STAGES-2:0], irq_timer};
      sync_e_q        <= {sync_e_q[SYNC_STAGES-2:0], irq_ext};
      mtip_q          <= sync_t_q[SYNC_STAGES-1];
      meip_q          <= sync_e_q[SYNC_STAGES-1];
      state_q         <= state_d;
      cause_q         <= cause_d;
      trap_q          <= trap_d;
      epc_wr_q        <= epc_wr_d;
      epc_wdata_q     <= epc_wdata_d;
      cause_wr_q      <= cause_wr_d;
      cause_wdata_q   <= cause_wdata_d;
      mstatus_wr_q    <= mstatus_wr_d;
      mstatus_wdata_q <= mstatus_wdata_d;
      flush_q         <= flush_d;
      redirect_q      <= redirect_d;
      redirect_pc_q   <= redirect_pc_d;
    end
  end

  assign mip_out       = {20'd0, meip_q, 3'd0, mtip_q, 7'd0};
  assign trap          = trap_q;
  assign epc_wr        = epc_wr_q;
  assign epc_wdata     = epc_wdata_q;
  assign cause_wr      = cause_wr_q;
  assign cause_wdata   = cause_wdata_q;
  assign mstatus_wr    = mstatus_wr_q;
  assign mstatus_wdata = mstatus_wdata_q;
  assign flush         = flush_q;
  assign redirect      = redirect_q;
  assign redirect_pc   = redirect_pc_q;

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Directed testbench for csr_irq_ctrl. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, so each tick observes the
// registered result of the previous edge.
module tb_csr_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_timer, irq_ext;
  logic [31:0] mstatus_in, mie_in, mtvec_in, epc_in;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        is_mret, stall;
  logic [31:0] mip_out;
  logic        trap, epc_wr, cause_wr, mstatus_wr, flush, redirect;
  logic [31:0] epc_wdata, cause_wdata, mstatus_wdata, redirect_pc;
  logic [5:0]  strobes;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // {trap, epc_wr, cause_wr, mstatus_wr, flush, redirect}
  assign strobes = {trap, epc_wr, cause_wr, mstatus_wr, flush, redirect};

  csr_irq_ctrl #(.SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .irq_timer(irq_timer), .irq_ext(irq_ext),
    .mstatus_in(mstatus_in), .mie_in(mie_in), .mtvec_in(mtvec_in), .epc_in(epc_in),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .is_mret(is_mret), .stall(stall),
    .mip_out(mip_out), .trap(trap),
    .epc_wr(epc_wr), .epc_wdata(epc_wdata),
    .cause_wr(cause_wr), .cause_wdata(cause_wdata),
    .mstatus_wr(mstatus_wr), .mstatus_wdata(mstatus_wdata),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_irqs();
    irq_timer = 1'b0;
    irq_ext   = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; irq_ext = 1'b1; irq_timer = 1'b0;
    mstatus_in = 32'h8; mie_in = 32'h880; mtvec_in = 32'h200; epc_in = 32'h0;
    inst_valid = 1'b1; inst_pc = 32'h40; is_mret = 1'b0; stall = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({strobes, epc_wdata, cause_wdata, mstatus_wdata, redirect_pc, mip_out} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: strobes=%b epc=%h cause=%h mst=%h rpc=%h mip=%h required all 0",
               strobes, epc_wdata, cause_wdata, mstatus_wdata, redirect_pc, mip_out);
    end
    inst_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if (mip_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mip_early: got %h required %h", mip_out, 32'h0);
    end
    tick();
    tests_run++;
    if (mip_out !== 32'h800) begin
      tests_failed++;
      $display("FAIL reset_mip_latency: got %h required %h", mip_out, 32'h800);
    end
    clear_irqs();
  endtask

  task automatic test_timer();
    mstatus_in = 32'h8; mie_in = 32'h80; mtvec_in = 32'h200; irq_timer = 1'b1;
    repeat (4) tick();
    tests_run++;
    if (mip_out !== 32'h80) begin
      tests_failed++;
      $display("FAIL timer_mip: got %h required %h", mip_out, 32'h80);
    end
    inst_valid = 1'b1; inst_pc = 32'h100;
    tick();
    inst_valid = 1'b0;
    tests_run++;
    if (strobes !== 6'b111010 || epc_wdata !== 32'h100 || cause_wdata !== 32'h8000_0007 ||
        mstatus_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL timer_save: strobes=%b epc=%h cause=%h mst=%h rpc=%h required 111010 100 80000007 0 0",
               strobes, epc_wdata, cause_wdata, mstatus_wdata, redirect_pc);
    end
    tick();
    tests_run++;
    if (strobes !== 6'b000111 || mstatus_wdata !== 32'h1880 || redirect_pc !== 32'h200 ||
        epc_wdata !== 32'h0 || cause_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL timer_stat: strobes=%b mst=%h rpc=%h epc=%h cause=%h required 000111 1880 200 0 0",
               strobes, mstatus_wdata, redirect_pc, epc_wdata, cause_wdata);
    end
    tick();
    tests_run++;
    if (strobes !== 6'b000000) begin
      tests_failed++;
      $display("FAIL timer_idle_after: strobes=%b required 000000", strobes);
    end
    clear_irqs();
  endtask

  task automatic test_vectored_priority();
    mstatus_in = 32'h8; mie_in = 32'h880; mtvec_in = 32'h201;
    irq_timer = 1'b1; irq_ext = 1'b1;
    repeat (4) tick();
    inst_valid = 1'b1; inst_pc = 32'h300;
    tick();
    inst_valid = 1'b0;
    tests_run++;
    if (strobes !== 6'b111010 || cause_wdata !== 32'h8000_000B || epc_wdata !== 32'h300) begin
      tests_failed++;
      $display("FAIL vec_save_ext: strobes=%b cause=%h epc=%h required 111010 8000000b 300",
               strobes, cause_wdata, epc_wdata);
    end
    tick();
    tests_run++;
    if (strobes !== 6'b000111 || redirect_pc !== 32'h22C || mstatus_wdata !== 32'h1880) begin
      tests_failed++;
      $display("FAIL vec_stat_ext: strobes=%b rpc=%h mst=%h required 000111 22c 1880",
               strobes, redirect_pc, mstatus_wdata);
    end
    // The timer stayed pending and is taken once the external line drops.
    irq_ext = 1'b0;
    repeat (4) tick();
    inst_valid = 1'b1; inst_pc = 32'h304;
    tick();
    inst_valid = 1'b0;
    tests_run++;
    if (strobes !== 6'b111010 || cause_wdata !== 32'h8000_0007 || epc_wdata !== 32'h304) begin
      tests_failed++;
      $display("FAIL vec_save_timer: strobes=%b cause=%h epc=%h required 111010 80000007 304",
               strobes, cause_wdata, epc_wdata);
    end
    tick();
    tests_run++;
    if (redirect_pc !== 32'h21C || redirect !== 1'b1) begin
      tests_failed++;
      $display("FAIL vec_stat_timer: rpc=%h redirect=%b required 21c 1", redirect_pc, redirect);
    end
    tick();
    clear_irqs();
  endtask

  task automatic test_gating();
    int traps;
    mtvec_in = 32'h200; mie_in = 32'h80; mstatus_in = 32'h0; irq_timer = 1'b1;
    repeat (4) tick();
    inst_valid = 1'b1; inst_pc = 32'h500;
    traps = 0;
    repeat (10) begin tick(); if (trap !== 1'b0) traps++; end
    tests_run++;
    if (traps !== 0) begin
      tests_failed++;
      $display("FAIL gate_mie: traps=%0d required 0", traps);
    end
    mstatus_in = 32'h8; stall = 1'b1;
    traps = 0;
    repeat (10) begin tick(); if (trap !== 1'b0) traps++; end
    tests_run++;
    if (traps !== 0) begin
      tests_failed++;
      $display("FAIL gate_stall: traps=%0d required 0", traps);
    end
    stall = 1'b0; mie_in = 32'h0;
    traps = 0;
    repeat (10) begin tick(); if (trap !== 1'b0) traps++; end
    tests_run++;
    if (traps !== 0) begin
      tests_failed++;
      $display("FAIL gate_mtie: traps=%0d required 0", traps);
    end
    mie_in = 32'h80;
    tick();
    inst_valid = 1'b0;
    tests_run++;
    if (trap !== 1'b1 || epc_wdata !== 32'h500 || cause_wdata !== 32'h8000_0007) begin
      tests_failed++;
      $display("FAIL gate_release: trap=%b epc=%h cause=%h required 1 500 80000007",
               trap, epc_wdata, cause_wdata);
    end
    tick(); tick();
    clear_irqs();
  endtask

  task automatic test_mret();
    mstatus_in = 32'h80; epc_in = 32'h104;
    inst_valid = 1'b1; is_mret = 1'b1; inst_pc = 32'h180;
    tick();
    inst_valid = 1'b0; is_mret = 1'b0;
    tests_run++;
    if (strobes !== 6'b000111 || mstatus_wdata !== 32'h88 || redirect_pc !== 32'h104 ||
        epc_wdata !== 32'h0 || cause_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL mret_ret: strobes=%b mst=%h rpc=%h epc=%h cause=%h required 000111 88 104 0 0",
               strobes, mstatus_wdata, redirect_pc, epc_wdata, cause_wdata);
    end
    tick();
    tests_run++;
    if (strobes !== 6'b000000 || mstatus_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL mret_idle_after: strobes=%b mst=%h rpc=%h required 000000 0 0",
               strobes, mstatus_wdata, redirect_pc);
    end
    // MPP kept, MIE takes MPIE=0, low epc bits dropped.
    mstatus_in = 32'h1800; epc_in = 32'h10B;
    inst_valid = 1'b1; is_mret = 1'b1;
    tick();
    inst_valid = 1'b0; is_mret = 1'b0;
    tests_run++;
    if (mstatus_wdata !== 32'h1880 || redirect_pc !== 32'h108 || mstatus_wr !== 1'b1) begin
      tests_failed++;
      $display("FAIL mret_mpp_align: mst=%h rpc=%h mstatus_wr=%b required 1880 108 1",
               mstatus_wdata, redirect_pc, mstatus_wr);
    end
    tick();
  endtask

  task automatic test_collision_reset();
    int bad;
    mtvec_in = 32'h200; mie_in = 32'h800; mstatus_in = 32'h8; epc_in = 32'h500; irq_ext = 1'b1;
    repeat (4) tick();
    inst_valid = 1'b1; is_mret = 1'b1; inst_pc = 32'h400;
    tick();
    inst_valid = 1'b0; is_mret = 1'b0;
    tests_run++;
    if (strobes !== 6'b111010 || epc_wdata !== 32'h400 || cause_wdata !== 32'h8000_000B) begin
      tests_failed++;
      $display("FAIL collide_save: strobes=%b epc=%h cause=%h required 111010 400 8000000b",
               strobes, epc_wdata, cause_wdata);
    end
    tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if (strobes !== 6'b000000 || mstatus_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
      tests_failed++;
      $display("FAIL collide_reset_async: strobes=%b mst=%h rpc=%h required 000000 0 0",
               strobes, mstatus_wdata, redirect_pc);
    end
    irq_ext = 1'b0;
    tick(); tick();
    rst = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (strobes !== 6'b000000) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL collide_after_release: cycles_with_strobes=%0d required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_vectored_priority();
    test_gating();
    test_mret();
    test_collision_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
